// File: rtl/riscv_structures.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | riscv_structures                                                   |
// | Shared memory-stage state encoding, funct3 codes and helpers.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package riscv_structures;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RMW   = 3'd2,
      STORE = 3'd3,
      RESP  = 3'd4
   } mau_state_t;

   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      if (write)
         return !((f3 == c_F3_B) || (f3 == c_F3_H) || (f3 == c_F3_W));
      return (f3 == 3'b011) || (f3[2:1] == 2'b11);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
   endfunction

   // Clears only the address bits that would misalign the access width.
   function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return {lo[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lo;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mau_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mau_lane_align                                                     |
// | Byte/half lane extraction with extension, and store lane merge.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mau_lane_align
   import riscv_structures::*;
(
   input  logic [31:0] rd_word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = rd_word[{addr_lo, 3'b000} +: 8];
   assign w_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = rd_word;
      case (funct3)
         c_F3_B:  load_data = {{24{w_byte[7]}}, w_byte};
         c_F3_BU: load_data = {24'h000000, w_byte};
         c_F3_H:  load_data = {{16{w_half[15]}}, w_half};
         c_F3_HU: load_data = {16'h0000, w_half};
         default: load_data = rd_word;
      endcase
   end

   always_comb begin
      merged_word = rd_word;
      case (funct3[1:0])
         2'b00:   merged_word[{addr_lo, 3'b000} +: 8]      = wdata[7:0];
         2'b01:   merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged_word = wdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit                                                    |
// | RV32I load/store unit with sub-word read-modify-write.             |
// | Optional macro MAU_MISALIGN_TRAP_EN: misaligned accesses fault.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_access_unit
   import riscv_structures::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   mau_state_t  r_state;
   mau_state_t  w_next_state;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_word;
   logic [31:0] r_data;
   logic        r_fault;

   logic        w_accept;
   logic        w_fault;
   logic [31:0] w_addr;
   logic [31:0] w_load_data;
   logic [31:0] w_merged_word;

   assign w_accept = req_valid && (r_state == IDLE);

`ifdef MAU_MISALIGN_TRAP_EN
   assign w_fault = f3_illegal(req_write, req_funct3) ||
                    is_misaligned(req_funct3, req_addr[1:0]);
   assign w_addr  = req_addr;
`else
   assign w_fault = f3_illegal(req_write, req_funct3);
   assign w_addr  = {req_addr[31:2], align_lo(req_funct3, req_addr[1:0])};
`endif

   mau_lane_align u_lane_align (
      .rd_word     (mem_read_data),
      .addr_lo     (r_addr[1:0]),
      .funct3      (r_funct3),
      .wdata       (r_word),
      .load_data   (w_load_data),
      .merged_word (w_merged_word)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // r_word holds the store data until RMW overwrites it with the merged word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_funct3 <= 3'b000;
         r_addr   <= 32'h0;
         r_word   <= 32'h0;
         r_data   <= 32'h0;
         r_fault  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_funct3 <= req_funct3;
                  r_addr   <= w_addr;
                  r_word   <= req_wdata;
                  r_data   <= 32'h0;
                  r_fault  <= w_fault;
               end
            end
            LOAD:    r_data <= w_load_data;
            RMW:     r_word <= w_merged_word;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state     = r_state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      resp_fault       = 1'b0;
      resp_data        = 32'h0;
      mem_address      = 32'h0;
      mem_write_data   = 32'h0;
      mem_write_enable = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (w_accept) begin
               if (w_fault)
                  w_next_state = RESP;
               else if (!req_write)
                  w_next_state = LOAD;
               else if (req_funct3 == c_F3_W)
                  w_next_state = STORE;
               else
                  w_next_state = RMW;
            end
         end
         LOAD: begin
            mem_address  = {r_addr[31:2], 2'b00};
            w_next_state = RESP;
         end
         RMW: begin
            mem_address  = {r_addr[31:2], 2'b00};
            w_next_state = STORE;
         end
         STORE: begin
            mem_address      = {r_addr[31:2], 2'b00};
            mem_write_data   = r_word;
            mem_write_enable = !rst;
            w_next_state     = RESP;
         end
         RESP: begin
            resp_valid   = 1'b1;
            resp_fault   = r_fault;
            resp_data    = r_data;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit                                                 |
// | Directed scoreboard bench; honours MAU_MISALIGN_TRAP_EN.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_fault;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   logic        mem_init;
   logic [31:0] mem [0:15];

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic        fault;
      logic [31:0] data;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .resp_fault       (resp_fault),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data)
   );

   assign mem_read_data = mem[mem_address[5:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'hDEADBEEF;
         mem[1] <= 32'h12345678;
         mem[2] <= 32'hA5A5A5A5;
      end else if (mem_write_enable) begin
         mem[mem_address[5:2]] <= mem_write_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                              input logic [2:0] f3);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   // Pops the oldest expectation and compares it with the response on the bus now.
   task automatic pop_check(input string tag, input int lat);
      exp_t e;
      check($sformatf("%s.valid", tag), resp_valid, 1'b1);
      if (sb_q.size() == 0) begin
         check($sformatf("%s.sb_empty", tag), 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check($sformatf("%s.fault", tag), resp_fault, e.fault);
         check($sformatf("%s.data", tag), resp_data, e.data);
         check($sformatf("%s.lat", tag), lat, e.lat);
      end
   endtask

   task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_fault, input logic [31:0] exp_data, input int exp_lat,
                          input logic exp_wr, input int exp_wr_k,
                          input logic [31:0] exp_wr_addr, input logic [31:0] exp_wr_data);
      exp_t        e;
      logic        got;
      int          wr_cnt;
      int          wr_k;
      logic [31:0] wr_a;
      logic [31:0] wr_d;
      @(negedge clk);
      check($sformatf("%s.ready", tag), req_ready, 1'b1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      e.fault = exp_fault;
      e.data  = exp_data;
      e.lat   = exp_lat;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      got = 1'b0; wr_cnt = 0; wr_k = 0; wr_a = 32'h0; wr_d = 32'h0;
      for (int k = 1; k <= 6 && !got; k++) begin
         if (mem_write_enable) begin
            wr_cnt++; wr_k = k; wr_a = mem_address; wr_d = mem_write_data;
         end
         if (resp_valid) begin
            got = 1'b1;
            pop_check(tag, k);
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         check($sformatf("%s.timeout", tag), 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      check($sformatf("%s.wr_count", tag), wr_cnt, exp_wr ? 1 : 0);
      if (exp_wr) begin
         check($sformatf("%s.wr_cycle", tag), wr_k, exp_wr_k);
         check($sformatf("%s.wr_addr", tag), wr_a, exp_wr_addr);
         check($sformatf("%s.wr_data", tag), wr_d, exp_wr_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        seen;
      logic [31:0] saved;
      rst = 1'b1; mem_init = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;

      repeat (2) @(negedge clk);
      check("rst.we_during", mem_write_enable, 1'b0);
      rst = 1'b0; mem_init = 1'b0;
      @(negedge clk);
      check("rst.ready", req_ready, 1'b1);
      check("rst.resp_valid", resp_valid, 1'b0);
      check("rst.resp_fault", resp_fault, 1'b0);
      check("rst.resp_data", resp_data, 32'h0);
      check("rst.mem_address", mem_address, 32'h0);
      check("rst.mem_wdata", mem_write_data, 32'h0);
      check("rst.we", mem_write_enable, 1'b0);

      run_req("lb_3",  1'b0, 3'b000, 32'h3, 32'h0, 1'b0, 32'hFFFFFFDE, 2, 1'b0, 0, 32'h0, 32'h0);
      run_req("lbu_3", 1'b0, 3'b100, 32'h3, 32'h0, 1'b0, 32'h000000DE, 2, 1'b0, 0, 32'h0, 32'h0);
      run_req("lh_0",  1'b0, 3'b001, 32'h0, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1'b0, 0, 32'h0, 32'h0);

      for (int f = 0; f < 8; f++) begin
         if (f == 3 || f > 5) continue;
         for (int o = 0; o < 4; o++) begin
            if ((f % 4 == 1 && o % 2 != 0) || (f == 2 && o != 0)) continue;
            run_req($sformatf("ld_f%0d_o%0d", f, o), 1'b0, 3'(f), 32'(o), 32'h0,
                    1'b0, model_load(32'hDEADBEEF, o, 3'(f)), 2, 1'b0, 0, 32'h0, 32'h0);
         end
      end

      run_req("sh_6", 1'b1, 3'b001, 32'h6, 32'h0000BEEF, 1'b0, 32'h0, 3,
              1'b1, 2, 32'h4, 32'hBEEF5678);
      run_req("lw_4", 1'b0, 3'b010, 32'h4, 32'h0, 1'b0, 32'hBEEF5678, 2, 1'b0, 0, 32'h0, 32'h0);

`ifdef MAU_MISALIGN_TRAP_EN
      run_req("lw_2_mis", 1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);
      run_req("lh_3_mis", 1'b0, 3'b001, 32'h3, 32'h0, 1'b1, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);
      run_req("sw_5_mis", 1'b1, 3'b010, 32'h5, 32'h1, 1'b1, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);
`else
      run_req("lw_2_mis", 1'b0, 3'b010, 32'h2, 32'h0, 1'b0, 32'hDEADBEEF, 2, 1'b0, 0, 32'h0, 32'h0);
      run_req("lh_3_mis", 1'b0, 3'b001, 32'h3, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 1'b0, 0, 32'h0, 32'h0);
`endif

      run_req("st_f011", 1'b1, 3'b011, 32'h0, 32'h11223344, 1'b1, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);
      run_req("ld_f110", 1'b0, 3'b110, 32'h0, 32'h0, 1'b1, 32'h0, 1, 1'b0, 0, 32'h0, 32'h0);

      // Reset during the RMW cycle of an SB
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h1; req_wdata = 32'h00000055;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      #1 check("abort_rmw.we", mem_write_enable, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_rmw.ready", req_ready, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (resp_valid || mem_write_enable) seen = 1'b1;
         @(negedge clk);
      end
      check("abort_rmw.quiet", seen, 1'b0);
      saved = mem[0];
      check("abort_rmw.word", saved, 32'hDEADBEEF);

      // Reset during the STORE cycle of an SW must suppress the write strobe
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h8; req_wdata = 32'h11111111;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_st.we_before", mem_write_enable, 1'b1);
      rst = 1'b1;
      #1 check("abort_st.we_rst", mem_write_enable, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_st.ready", req_ready, 1'b1);
      check("abort_st.resp", resp_valid, 1'b0);
      saved = mem[2];
      check("abort_st.word", saved, 32'hA5A5A5A5);

      run_req("sb_9", 1'b1, 3'b000, 32'h9, 32'h00000077, 1'b0, 32'h0, 3,
              1'b1, 2, 32'h8, 32'hA5A577A5);

      // SW then LW with req_valid held high throughout
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'hC; req_wdata = 32'hCAFEF00D;
      sb_q.push_back('{fault: 1'b0, data: 32'h0, lat: 2});
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b0; req_wdata = 32'h0;
      check("b2b.ready1", req_ready, 1'b0);
      check("b2b.we1", mem_write_enable, 1'b1);
      check("b2b.wdata1", mem_write_data, 32'hCAFEF00D);
      @(negedge clk);
      check("b2b.ready2", req_ready, 1'b0);
      pop_check("b2b.sw", 2);
      sb_q.push_back('{fault: 1'b0, data: 32'hCAFEF00D, lat: 2});
      @(negedge clk);
      check("b2b.ready3", req_ready, 1'b1);
      check("b2b.no_resp3", resp_valid, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b.ready4", req_ready, 1'b0);
      check("b2b.addr4", mem_address, 32'hC);
      @(negedge clk);
      pop_check("b2b.lw", 2);
      @(negedge clk);
      check("b2b.idle", req_ready, 1'b1);
      check("sb.drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
